// File: rtl/seq_alu_pipe.sv
// seq_alu_pipe: two-stage signed ALU with valid/ready on both sides.
// S1 registers the command, S2 computes and registers the result and flags.
// A WIDTH+1-bit accumulator (saturating or wrapping) is read and updated
// by ACC/CLR as they move from S1 to S2, so back-to-back accumulator
// commands need no bubble.
module seq_alu_pipe #(
    parameter int WIDTH  = 4,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   C,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MAX = 3'b101,
        OP_ACC = 3'b110,
        OP_CLR = 3'b111
    } op_t;

    logic             s1_valid;
    op_t              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH:0]   acc;

    logic s2_adv;
    logic s1_adv;

    // S2 may load when empty or when its result leaves; S1 may load when
    // empty or when it can hand off to S2. No skid buffer, so in_ready is
    // combinational from out_ready.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    logic signed [WIDTH:0]   ax;
    logic signed [WIDTH:0]   bx;
    logic signed [WIDTH:0]   res;
    logic signed [WIDTH+1:0] sum;
    logic                    ovf;
    logic                    v_nxt;
    logic [WIDTH:0]          acc_nxt;

    // S2 datapath: sign-extend operands, compute result, accumulator update
    always_comb begin
        ax      = {s1_a[WIDTH-1], s1_a};
        bx      = {s1_b[WIDTH-1], s1_b};
        // One extra bit of headroom; top two bits differing means the sum
        // left the WIDTH+1-bit signed range.
        sum     = {acc[WIDTH], acc} + {{2{s1_a[WIDTH-1]}}, s1_a};
        ovf     = sum[WIDTH+1] != sum[WIDTH];
        res     = '0;
        v_nxt   = 1'b0;
        acc_nxt = acc;
        case (s1_op)
            OP_ADD: res = ax + bx;
            OP_SUB: res = ax - bx;
            OP_AND: res = ax & bx;
            OP_OR:  res = ax | bx;
            OP_XOR: res = ax ^ bx;
            OP_MAX: res = (ax > bx) ? ax : bx;
            OP_ACC: begin
                if (ovf && SAT_EN)
                    res = sum[WIDTH+1] ? {1'b1, {WIDTH{1'b0}}} : {1'b0, {WIDTH{1'b1}}};
                else
                    res = sum[WIDTH:0];
                v_nxt   = ovf;
                acc_nxt = res;
            end
            OP_CLR: begin
                res     = acc;
                acc_nxt = '0;
            end
            default: res = '0;
        endcase
    end

    // S1: capture the command whenever the stage is free to advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op_t'(opcode);
                s1_a  <= A;
                s1_b  <= B;
            end
        end
    end

    // S2: register result, flags and accumulator; hold while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            C         <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            acc       <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                C      <= res;
                flag_z <= (res == '0);
                flag_n <= res[WIDTH];
                flag_v <= v_nxt;
                acc    <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu_pipe.sv
// Bench for seq_alu_pipe: three instances (W4 saturating, W4 wrapping,
// W8 saturating) share one command stream; each has its own reference
// model and in-order scoreboard.
module tb_seq_alu_pipe;

    typedef struct {
        int c;
        bit z;
        bit n;
        bit v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [2:0] opcode;
    logic [7:0] a8;
    logic [7:0] b8;

    logic       ir_s, ov_s, z_s, n_s, v_s;
    logic [4:0] c_s;
    logic       ir_w, ov_w, z_w, n_w, v_w;
    logic [4:0] c_w;
    logic       ir_8, ov_8, z_8, n_8, v_8;
    logic [8:0] c_8;

    int   checks   = 0;
    int   failures = 0;
    exp_t q_s[$];
    exp_t q_w[$];
    exp_t q_8[$];
    exp_t e_s, e_w, e_8;
    int   acc_s = 0;
    int   acc_w = 0;
    int   acc_8 = 0;
    bit   took;

    seq_alu_pipe #(.WIDTH(4), .SAT_EN(1'b1)) u_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s), .opcode(opcode),
        .A(a8[3:0]), .B(b8[3:0]), .out_valid(ov_s), .out_ready(out_ready), .C(c_s),
        .flag_z(z_s), .flag_n(n_s), .flag_v(v_s));

    seq_alu_pipe #(.WIDTH(4), .SAT_EN(1'b0)) u_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w), .opcode(opcode),
        .A(a8[3:0]), .B(b8[3:0]), .out_valid(ov_w), .out_ready(out_ready), .C(c_w),
        .flag_z(z_w), .flag_n(n_w), .flag_v(v_w));

    seq_alu_pipe #(.WIDTH(8), .SAT_EN(1'b1)) u_8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_8), .opcode(opcode),
        .A(a8), .B(b8), .out_valid(ov_8), .out_ready(out_ready), .C(c_8),
        .flag_z(z_8), .flag_n(n_8), .flag_v(v_8));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input integer act, input integer exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Reference model on plain ints; operands arrive already sign-extended.
    function automatic exp_t model(input int w, input bit sat, input int op,
                                   input int a, input int b, inout int acc);
        exp_t r;
        int   hi, lo, s;
        hi  = (1 << w) - 1;
        lo  = -(1 << w);
        r.c = 0;
        r.v = 1'b0;
        case (op)
            0: r.c = a + b;
            1: r.c = a - b;
            2: r.c = a & b;
            3: r.c = a | b;
            4: r.c = a ^ b;
            5: r.c = (a > b) ? a : b;
            6: begin
                s = acc + a;
                if (s > hi || s < lo) begin
                    r.v = 1'b1;
                    if (sat) s = (s > hi) ? hi : lo;
                    else     s = ((s - lo) & ((1 << (w + 1)) - 1)) + lo;
                end
                acc = s;
                r.c = s;
            end
            default: begin
                r.c = acc;
                acc = 0;
            end
        endcase
        r.z = (r.c == 0);
        r.n = (r.c < 0);
        return r;
    endfunction

    // Scoreboard: compare delivered results, then record newly accepted commands
    always @(negedge clk) begin
        if (rst) begin
            if (ov_s && out_ready) begin
                if (q_s.size() == 0) chk("s4_extra", 1, 0);
                else begin
                    e_s = q_s.pop_front();
                    chk("s4_c", $signed(c_s), e_s.c);
                    chk("s4_zfv", {z_s, n_s, v_s}, {e_s.z, e_s.n, e_s.v});
                end
            end
            if (ov_w && out_ready) begin
                if (q_w.size() == 0) chk("w4_extra", 1, 0);
                else begin
                    e_w = q_w.pop_front();
                    chk("w4_c", $signed(c_w), e_w.c);
                    chk("w4_zfv", {z_w, n_w, v_w}, {e_w.z, e_w.n, e_w.v});
                end
            end
            if (ov_8 && out_ready) begin
                if (q_8.size() == 0) chk("s8_extra", 1, 0);
                else begin
                    e_8 = q_8.pop_front();
                    chk("s8_c", $signed(c_8), e_8.c);
                    chk("s8_zfv", {z_8, n_8, v_8}, {e_8.z, e_8.n, e_8.v});
                end
            end
            if (in_valid && ir_s)
                q_s.push_back(model(4, 1'b1, opcode, $signed(a8[3:0]), $signed(b8[3:0]), acc_s));
            if (in_valid && ir_w)
                q_w.push_back(model(4, 1'b0, opcode, $signed(a8[3:0]), $signed(b8[3:0]), acc_w));
            if (in_valid && ir_8)
                q_8.push_back(model(8, 1'b1, opcode, $signed(a8), $signed(b8), acc_8));
        end
    end

    // Offer one command and hold it until accepted (bounded)
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bit done;
        done     = 1'b0;
        opcode   = op;
        a8       = a;
        b8       = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (ir_s) done = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = 3'd0; a8 = 8'd0; b8 = 8'd0;
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", ov_s, 0);
        chk("rst_c", c_s, 0);
        chk("rst_flags", {z_s, n_s, v_s}, 0);
        rst = 1'b1;
        idle(1);
        chk("idle_in_ready", ir_s, 1);

        // Basic ops, two-cycle latency
        send(3'd0, 8'd7, 8'd7);
        chk("lat_after_1", ov_s, 0);
        idle(1);
        chk("lat_after_2", ov_s, 1);
        chk("add77_c", $signed(c_s), 14);
        send(3'd1, 8'hF8, 8'h07);
        send(3'd5, 8'hFD, 8'h02);
        send(3'd2, 8'hF8, 8'h07);
        send(3'd4, 8'h05, 8'hF3);
        send(3'd3, 8'h05, 8'h0A);
        idle(4);

        // Backpressure: two commands fit, third waits, C holds
        out_ready = 1'b0;
        send(3'd0, 8'd1, 8'd1);
        send(3'd0, 8'd2, 8'd2);
        opcode = 3'd0; a8 = 8'd3; b8 = 8'd3; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", ir_s, 0);
            chk("bp_out_valid", ov_s, 1);
            chk("bp_hold_c", $signed(c_s), 2);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", ir_s, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(4);

        // Accumulator: saturate / wrap, read-and-clear, negative run
        send(3'd7, 8'd0, 8'd0);
        send(3'd6, 8'd7, 8'd0);
        send(3'd6, 8'd7, 8'd0);
        send(3'd6, 8'd7, 8'd0);
        send(3'd7, 8'd0, 8'd0);
        send(3'd6, 8'd1, 8'd0);
        send(3'd7, 8'd0, 8'd0);
        repeat (4) send(3'd6, 8'hF8, 8'd0);
        idle(4);

        // Reset mid-flight discards in-flight work and the accumulator
        out_ready = 1'b0;
        send(3'd6, 8'd5, 8'd0);
        send(3'd6, 8'd5, 8'd0);
        #1 rst = 1'b0;
        #1;
        chk("midrst_out_valid", ov_s, 0);
        chk("midrst_c", c_s, 0);
        chk("midrst_flags", {z_s, n_s, v_s}, 0);
        q_s.delete(); q_w.delete(); q_8.delete();
        acc_s = 0; acc_w = 0; acc_8 = 0;
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_no_stale", ov_s, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd6, 8'd3, 8'd0);
        idle(1);
        chk("postrst_acc3", $signed(c_s), 3);
        idle(3);

        // Random mix with random valid/ready; source holds until taken
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            took = in_valid && ir_s;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                opcode   = 3'($urandom_range(0, 7));
                a8       = 8'($urandom);
                b8       = 8'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (q_s.size() + q_w.size() + q_8.size()) != 0; i++)
            idle(1);
        idle(1);
        chk("drain_empty", q_s.size() + q_w.size() + q_8.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
